// File: rtl/servo_frame_modulator.sv
// rtl/servo_frame_modulator.sv - multi-channel 50 Hz servo pulse generator with accumulator-spread power level
// Optional reversal guard: define SERVO_REVERSE_GUARD_EN.
module servo_frame_modulator #(
    parameter int CHANNELS     = 2,
    parameter int LEVEL_BITS   = 4,
    parameter int CLK_RATE     = 100000000,
    parameter int FRAME_US     = 20000,
    parameter int FWD_US       = 1000,
    parameter int NEU_US       = 1500,
    parameter int REV_US       = 2000,
    parameter int GUARD_FRAMES = 2
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [CHANNELS*(LEVEL_BITS+2)-1:0]   ModInfo,
    output logic [CHANNELS-1:0]                  Servo,
    output logic [CHANNELS-1:0]                  Active,
    output logic                                 FrameTick
);
    localparam int CPU       = CLK_RATE / 1000000;
    localparam int FRAME_CYC = FRAME_US * CPU;
    localparam int CW        = $clog2(FRAME_CYC);
    localparam int SW        = LEVEL_BITS + 2;
    localparam int LMAX      = (1 << LEVEL_BITS) - 1;
    localparam logic [CW-1:0] FWD_W = CW'(FWD_US * CPU);
    localparam logic [CW-1:0] NEU_W = CW'(NEU_US * CPU);
    localparam logic [CW-1:0] REV_W = CW'(REV_US * CPU);
    localparam logic [CW-1:0] LAST  = CW'(FRAME_CYC - 1);

    if (FWD_US * CPU >= FRAME_CYC || NEU_US * CPU >= FRAME_CYC ||
        REV_US * CPU >= FRAME_CYC || GUARD_FRAMES < 0) begin : g_bad_params
        $error("servo_frame_modulator: pulse widths must be shorter than the frame");
    end

    logic [CW-1:0] cnt;
    logic          boundary;

    assign boundary = (cnt == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            FrameTick <= 1'b0;
        end else begin
            cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
            FrameTick <= boundary;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]            nd;
        logic [LEVEL_BITS-1:0] nl;
        logic [1:0]            ldir;
        logic [LEVEL_BITS-1:0] acc, acc_n, base;
        logic [LEVEL_BITS:0]   sum;
        logic                  drv_dir, drive;
        logic [CW-1:0]         wid, wid_n;
        logic                  servo_r, active_r;

        assign nd      = ModInfo[c*SW +: 2];
        assign nl      = ModInfo[c*SW + 2 +: LEVEL_BITS];
        assign drv_dir = (nd == 2'd0) || (nd == 2'd2);

`ifdef SERVO_REVERSE_GUARD_EN
        localparam int GW = $clog2(GUARD_FRAMES + 1) + 1;
        logic [GW-1:0] gcnt, gcnt_n, g_eff;
        logic [1:0]    rdir;
        logic          rvalid, rev_hit;
`endif

        always_comb begin
            base  = (nd != ldir) ? '0 : acc;
            sum   = {1'b0, base} + {1'b0, nl};
            drive = 1'b0;
            acc_n = acc;
            if (drv_dir && nl != '0) begin
                if (sum >= (LEVEL_BITS+1)'(LMAX)) begin
                    drive = 1'b1;
                    acc_n = LEVEL_BITS'(sum - (LEVEL_BITS+1)'(LMAX));
                end else begin
                    acc_n = sum[LEVEL_BITS-1:0];
                end
            end
`ifdef SERVO_REVERSE_GUARD_EN
            // A forward<->reverse flip against the last driven direction forces neutral frames.
            rev_hit = drv_dir && rvalid && (nd != rdir);
            g_eff   = rev_hit ? GW'(GUARD_FRAMES) : gcnt;
            gcnt_n  = '0;
            if (g_eff != '0) begin
                drive  = 1'b0;
                acc_n  = '0;
                gcnt_n = g_eff - 1'b1;
            end
`endif
            wid_n = drive ? ((nd == 2'd0) ? FWD_W : REV_W) : NEU_W;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                ldir     <= 2'd1;
                acc      <= '0;
                wid      <= NEU_W;
                servo_r  <= 1'b0;
                active_r <= 1'b0;
`ifdef SERVO_REVERSE_GUARD_EN
                gcnt     <= '0;
                rdir     <= 2'd1;
                rvalid   <= 1'b0;
`endif
            end else begin
                // Width chosen at count 0 takes effect immediately so the pulse spans counts 1..width.
                servo_r <= (cnt < (boundary ? wid_n : wid));
                if (boundary) begin
                    ldir     <= nd;
                    acc      <= acc_n;
                    wid      <= wid_n;
                    active_r <= drive;
`ifdef SERVO_REVERSE_GUARD_EN
                    gcnt     <= gcnt_n;
                    if (drv_dir) begin
                        rdir   <= nd;
                        rvalid <= 1'b1;
                    end
`endif
                end
            end
        end

        assign Servo[c]  = servo_r;
        assign Active[c] = active_r;
    end
endmodule
